sisc_fetch_unit: RTL and testbench



---
 rtl/sisc_pkg.sv | 37 +++
 rtl/sisc_fetch_unit_if.sv | 34 +++
 rtl/sisc_br_cond.sv | 30 +++
 rtl/sisc_fetch_unit.sv | 73 +++++++
 tb/tb_sisc_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field positions, datapath widths.
// Used by the fetch unit and the controller so both agree on encoding.
package sisc_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int RD_MSB  = 23;
    localparam int RD_LSB  = 20;
    localparam int RS_MSB  = 19;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 12;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [3:0] {
        NOOP   = 4'd0,
        LOD    = 4'd1,
        STR    = 4'd2,
        SWP    = 4'd3,
        BRA    = 4'd4,
        BRR    = 4'd5,
        BNE    = 4'd6,
        BNR    = 4'd7,
        ALU_OP = 4'd8,
        HLT    = 4'd15
    } opcode_t;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Controller/memory <-> fetch unit signal bundle; master drives strobes, slave drives
// the registered PC, decoded IR fields, status and flags.
interface sisc_fetch_unit_if;
    import sisc_pkg::*;

    logic       ir_load;
    logic       pc_write;
    logic       br_sel;
    logic       stat_en;
    logic [3:0] cc_in;
    instr_t     instr_in;

    pc_t        pc_out;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [15:0] imm;
    logic [3:0] stat;
    logic       br_taken;
    logic       halted;

    modport master (
        output ir_load, pc_write, br_sel, stat_en, cc_in, instr_in,
        input  pc_out, opcode, mm, rd, rs, rt, imm, stat, br_taken, halted
    );

    modport slave (
        input  ir_load, pc_write, br_sel, stat_en, cc_in, instr_in,
        output pc_out, opcode, mm, rd, rs, rt, imm, stat, br_taken, halted
    );

endinterface

// File: rtl/sisc_br_cond.sv
// Combinational branch resolution: taken flag and target from opcode, mm mask, status, PC, imm.
// Zero latency, no handshake; the caller qualifies the result with its own strobe.
module sisc_br_cond
    import sisc_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  mm,
    input  logic [3:0]  stat,
    input  pc_t         pc,
    input  logic [15:0] imm,
    output logic        taken,
    output pc_t         target
);

    logic hit;

    always_comb begin
        taken  = 1'b0;
        target = pc;
        hit    = |(mm & stat);
        case (opcode)
            BRA: begin taken = hit;  target = imm;      end
            BRR: begin taken = hit;  target = pc + imm; end
            BNE: begin taken = !hit; target = imm;      end
            BNR: begin taken = !hit; target = pc + imm; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: PC, IR, status and halt registers with decoded IR field outputs.
// Updates one edge after each strobe; no backpressure, all strobes ignored once halted.
module sisc_fetch_unit
    import sisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_f,
    sisc_fetch_unit_if.slave  bus
);

    pc_t        pc_q;
    instr_t     ir_q;
    logic [3:0] stat_q;
    logic       br_taken_q;
    logic       halted_q;

    logic       taken;
    pc_t        target;

    sisc_br_cond u_br_cond (
        .opcode (ir_q[OP_MSB:OP_LSB]),
        .mm     (ir_q[MM_MSB:MM_LSB]),
        .stat   (stat_q),
        .pc     (pc_q),
        .imm    (ir_q[IMM_MSB:IMM_LSB]),
        .taken  (taken),
        .target (target)
    );

    // Branch decisions read the pre-edge IR and stat, so same-edge loads never affect them.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q       <= '0;
            ir_q       <= '0;
            stat_q     <= '0;
            br_taken_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            br_taken_q <= 1'b0;
            if (ir_q[OP_MSB:OP_LSB] == HLT) begin
                halted_q <= 1'b1;
            end
            if (!halted_q) begin
                if (bus.ir_load) begin
                    ir_q <= bus.instr_in;
                end
                if (bus.stat_en) begin
                    stat_q <= bus.cc_in;
                end
                if (bus.pc_write) begin
                    if (!bus.br_sel) begin
                        pc_q <= pc_q + pc_t'(1);
                    end else if (taken) begin
                        pc_q       <= target;
                        br_taken_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.pc_out   = pc_q;
    assign bus.opcode   = ir_q[OP_MSB:OP_LSB];
    assign bus.mm       = ir_q[MM_MSB:MM_LSB];
    assign bus.rd       = ir_q[RD_MSB:RD_LSB];
    assign bus.rs       = ir_q[RS_MSB:RS_LSB];
    assign bus.rt       = ir_q[RT_MSB:RT_LSB];
    assign bus.imm      = ir_q[IMM_MSB:IMM_LSB];
    assign bus.stat     = stat_q;
    assign bus.br_taken = br_taken_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: sequential PC, branches, same-edge ordering, halt.
module tb_sisc_fetch_unit;
    import sisc_pkg::*;

    logic clk;
    logic rst_f;
    int   checks;
    int   errors;

    sisc_fetch_unit_if ifc ();

    sisc_fetch_unit dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ifc.ir_load  = 1'b0;
        ifc.instr_in = '0;
        ifc.stat_en  = 1'b0;
        ifc.cc_in    = '0;
        ifc.pc_write = 1'b0;
        ifc.br_sel   = 1'b0;
    endtask

    // Apply one set of strobes across a single rising edge; sample 1ns after it.
    task automatic cycle(input logic ld, input logic [31:0] ins, input logic se,
                         input logic [3:0] cc, input logic pw, input logic bs);
        ifc.ir_load  = ld;
        ifc.instr_in = ins;
        ifc.stat_en  = se;
        ifc.cc_in    = cc;
        ifc.pc_write = pw;
        ifc.br_sel   = bs;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        #2;
        if (ifc.pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", ifc.pc_out); end
        checks++;
        if (ifc.opcode !== 4'h0 || ifc.imm !== 16'h0000) begin errors++; $display("FAIL reset_ir got op %h imm %h want 0 0000", ifc.opcode, ifc.imm); end
        checks++;
        if (ifc.stat !== 4'h0) begin errors++; $display("FAIL reset_stat got %h want 0", ifc.stat); end
        checks++;
        if (ifc.br_taken !== 1'b0 || ifc.halted !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", ifc.br_taken, ifc.halted); end
        checks++;
        rst_f = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
            if (ifc.pc_out !== 16'(i)) begin errors++; $display("FAIL seq_pc%0d got %h want %h", i, ifc.pc_out, 16'(i)); end
            checks++;
        end
        #2;
        rst_f = 1'b0;
        #1;
        if (ifc.pc_out !== 16'h0000) begin errors++; $display("FAIL async_reset_pc got %h want 0000", ifc.pc_out); end
        checks++;
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    task automatic test_bra();
        cycle(1'b1, 32'h4100_0020, 1'b1, 4'h1, 1'b0, 1'b0);
        if (ifc.opcode !== 4'h4 || ifc.mm !== 4'h1 || ifc.imm !== 16'h0020 || ifc.stat !== 4'h1) begin
            errors++; $display("FAIL bra_load got op %h mm %h imm %h stat %h want 4 1 0020 1", ifc.opcode, ifc.mm, ifc.imm, ifc.stat);
        end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0020 || ifc.br_taken !== 1'b1) begin errors++; $display("FAIL bra_taken got pc %h bt %b want 0020 1", ifc.pc_out, ifc.br_taken); end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        if (ifc.br_taken !== 1'b0) begin errors++; $display("FAIL bra_pulse_width got %b want 0", ifc.br_taken); end
        checks++;
        cycle(1'b0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0020 || ifc.br_taken !== 1'b0) begin errors++; $display("FAIL bra_not_taken got pc %h bt %b want 0020 0", ifc.pc_out, ifc.br_taken); end
        checks++;
    endtask

    task automatic test_relative();
        cycle(1'b1, 32'h4100_0010, 1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0010) begin errors++; $display("FAIL bnr_setup_pc got %h want 0010", ifc.pc_out); end
        checks++;
        cycle(1'b1, 32'h7200_FFFE, 1'b1, 4'h0, 1'b0, 1'b0);
        if (ifc.opcode !== 4'h7 || ifc.mm !== 4'h2 || ifc.rt !== 4'hF || ifc.imm !== 16'hFFFE) begin
            errors++; $display("FAIL bnr_fields got op %h mm %h rt %h imm %h want 7 2 f fffe", ifc.opcode, ifc.mm, ifc.rt, ifc.imm);
        end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h000E || ifc.br_taken !== 1'b1) begin errors++; $display("FAIL bnr_wrap got pc %h bt %b want 000e 1", ifc.pc_out, ifc.br_taken); end
        checks++;
        cycle(1'b1, 32'h6200_0080, 1'b1, 4'h2, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h000E || ifc.br_taken !== 1'b0) begin errors++; $display("FAIL bne_not_taken got pc %h bt %b want 000e 0", ifc.pc_out, ifc.br_taken); end
        checks++;
        cycle(1'b0, 32'h0, 1'b1, 4'h4, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0080 || ifc.br_taken !== 1'b1) begin errors++; $display("FAIL bne_taken got pc %h bt %b want 0080 1", ifc.pc_out, ifc.br_taken); end
        checks++;
        cycle(1'b1, 32'h5100_0003, 1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0083 || ifc.br_taken !== 1'b1) begin errors++; $display("FAIL brr_taken got pc %h bt %b want 0083 1", ifc.pc_out, ifc.br_taken); end
        checks++;
    endtask

    task automatic test_non_branch();
        cycle(1'b1, 32'h8123_4567, 1'b1, 4'hF, 1'b0, 1'b0);
        if (ifc.opcode !== 4'h8 || ifc.mm !== 4'h1 || ifc.rd !== 4'h2 || ifc.rs !== 4'h3 || ifc.rt !== 4'h4 || ifc.imm !== 16'h4567) begin
            errors++; $display("FAIL decode_fields got %h %h %h %h %h %h want 8 1 2 3 4 4567", ifc.opcode, ifc.mm, ifc.rd, ifc.rs, ifc.rt, ifc.imm);
        end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0083 || ifc.br_taken !== 1'b0) begin errors++; $display("FAIL alu_no_branch got pc %h bt %b want 0083 0", ifc.pc_out, ifc.br_taken); end
        checks++;
    endtask

    task automatic test_pc_wrap();
        cycle(1'b1, 32'h4100_FFFF, 1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'hFFFF) begin errors++; $display("FAIL wrap_setup_pc got %h want ffff", ifc.pc_out); end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        if (ifc.pc_out !== 16'h0000 || ifc.br_taken !== 1'b0) begin errors++; $display("FAIL seq_wrap got pc %h bt %b want 0000 0", ifc.pc_out, ifc.br_taken); end
        checks++;
    endtask

    task automatic test_same_edge();
        cycle(1'b1, 32'h4100_0005, 1'b1, 4'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 4'h1, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0000 || ifc.br_taken !== 1'b0 || ifc.stat !== 4'h1) begin
            errors++; $display("FAIL old_stat_branch got pc %h bt %b stat %h want 0000 0 1", ifc.pc_out, ifc.br_taken, ifc.stat);
        end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0005 || ifc.br_taken !== 1'b1) begin errors++; $display("FAIL new_stat_branch got pc %h bt %b want 0005 1", ifc.pc_out, ifc.br_taken); end
        checks++;
        cycle(1'b1, 32'h4100_0040, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0000, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0040 || ifc.opcode !== 4'h0 || ifc.br_taken !== 1'b1) begin
            errors++; $display("FAIL old_ir_branch got pc %h op %h bt %b want 0040 0 1", ifc.pc_out, ifc.opcode, ifc.br_taken);
        end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0040 || ifc.br_taken !== 1'b0) begin errors++; $display("FAIL noop_branch got pc %h bt %b want 0040 0", ifc.pc_out, ifc.br_taken); end
        checks++;
    endtask

    task automatic test_halt();
        cycle(1'b1, 32'hF000_0000, 1'b0, 4'h0, 1'b0, 1'b0);
        if (ifc.opcode !== 4'hF || ifc.halted !== 1'b0) begin errors++; $display("FAIL halt_load got op %h halted %b want f 0", ifc.opcode, ifc.halted); end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        if (ifc.halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b want 1", ifc.halted); end
        checks++;
        cycle(1'b1, 32'h4100_0000, 1'b1, 4'hA, 1'b1, 1'b0);
        if (ifc.pc_out !== 16'h0040 || ifc.opcode !== 4'hF || ifc.stat !== 4'h1) begin
            errors++; $display("FAIL halt_ignore_seq got pc %h op %h stat %h want 0040 f 1", ifc.pc_out, ifc.opcode, ifc.stat);
        end
        checks++;
        cycle(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        if (ifc.pc_out !== 16'h0040 || ifc.br_taken !== 1'b0 || ifc.halted !== 1'b1) begin
            errors++; $display("FAIL halt_ignore_br got pc %h bt %b halted %b want 0040 0 1", ifc.pc_out, ifc.br_taken, ifc.halted);
        end
        checks++;
        #2;
        rst_f = 1'b0;
        #1;
        if (ifc.halted !== 1'b0 || ifc.pc_out !== 16'h0000 || ifc.opcode !== 4'h0) begin
            errors++; $display("FAIL halt_reset got halted %b pc %h op %h want 0 0000 0", ifc.halted, ifc.pc_out, ifc.opcode);
        end
        checks++;
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_f  = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_bra();
        test_relative();
        test_non_branch();
        test_pc_wrap();
        test_same_edge();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
